mac_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one registered multiply-accumulate datapath among NUM_REQ requesters.
- Each requester presents operands a, b, c with a request line.
- The block grants one requester at a time, captures its operands and computes out = a*b + c (truncated to DATA_WIDTH).
- It returns the result tagged with the requester id.
- Sits between small compute clients and a single shared MAC in micro-benchmark style designs.

---
 rtl/mac_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_mac_share_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_share_arbiter.sv
// -----------------------------------------------------------------------------
// mac_share_arbiter
//
// Shares a single registered multiply-accumulate datapath between NUM_REQ
// requesters. A round-robin arbiter picks one requester per operation,
// captures its operands, and one cycle later returns (a*b + c) truncated to
// DATA_WIDTH, tagged with the requester id.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester request lines
//   a_in       packed operand a, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_in       packed operand b, same packing
//   c_in       packed addend c, same packing
//   grant      registered one-hot grant, high for the single EXEC cycle
//   busy       high while an operation is in flight (EXEC)
//   out_valid  one-cycle result-valid pulse
//   out_id     requester id of the most recent result (held)
//   out_data   most recent result (held)
//   done_cnt   completed-operation counter, wraps
// -----------------------------------------------------------------------------
module mac_share_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  a_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  b_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  c_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           out_valid,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CNT_WIDTH-1:0]           done_cnt
);

  localparam int MAC_W = 2*DATA_WIDTH + 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0]     out_id_q, out_id_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]    done_cnt_q, done_cnt_d;
  logic [ID_WIDTH-1:0]     last_id_q, last_id_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;

  logic [ID_WIDTH-1:0]     win_id;
  logic [MAC_W-1:0]        mac_full;

  // Sum of last_id and an offset is always below 2*NUM_REQ, so one
  // conditional subtract gives the modulo.
  function automatic logic [ID_WIDTH-1:0] wrap_id(input int s);
    if (s >= NUM_REQ) return ID_WIDTH'(s - NUM_REQ);
    else              return ID_WIDTH'(s);
  endfunction

  // Round-robin search starting just after the last winner. Offsets are
  // scanned from farthest to nearest so the nearest set request is the
  // last assignment and therefore wins.
  always_comb begin
    win_id = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap_id(int'(last_id_q) + k)]) win_id = wrap_id(int'(last_id_q) + k);
    end
  end

  // Product and sum are formed at full precision before truncation.
  assign mac_full = MAC_W'(a_q) * MAC_W'(b_q) + MAC_W'(c_q);

  // Next-state logic: IDLE arbitrates and captures operands, EXEC retires
  // the captured operation. Requests and operands are ignored in EXEC.
  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    done_cnt_d  = done_cnt_q;
    last_id_d   = last_id_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = EXEC;
          grant_d   = NUM_REQ'(1) << win_id;
          last_id_d = win_id;
          a_d       = a_in[win_id*DATA_WIDTH +: DATA_WIDTH];
          b_d       = b_in[win_id*DATA_WIDTH +: DATA_WIDTH];
          c_d       = c_in[win_id*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      EXEC: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_id_d    = last_id_q;
        out_data_d  = DATA_WIDTH'(mac_full);
        done_cnt_d  = done_cnt_q + CNT_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. last_id resets to the top index so requester 0 has
  // priority on the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      done_cnt_q  <= '0;
      last_id_q   <= ID_WIDTH'(NUM_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      done_cnt_q  <= done_cnt_d;
      last_id_q   <= last_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == EXEC);
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_mac_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mac_share_arbiter
//
// Directed bench for mac_share_arbiter with the default parameters
// (DATA_WIDTH=2, NUM_REQ=4). A table of per-cycle vectors covers single
// requests, round-robin order and operand capture; hand-written sequences
// cover reset during an operation and counter wrap under continuous load.
// -----------------------------------------------------------------------------
module tb_mac_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] a_in, b_in, c_in;
  logic [3:0] grant;
  logic       busy;
  logic       out_valid;
  logic [1:0] out_id;
  logic [1:0] out_data;
  logic [7:0] done_cnt;

  int checks;
  int fails;

  mac_share_arbiter #(
    .DATA_WIDTH(2),
    .NUM_REQ   (4),
    .ID_WIDTH  (2),
    .CNT_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .grant    (grant),
    .busy     (busy),
    .out_valid(out_valid),
    .out_id   (out_id),
    .out_data (out_data),
    .done_cnt (done_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [3:0] grant;
    logic       busy;
    logic       valid;
    logic [1:0] id;
    logic [1:0] data;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // Appends one row: inputs held across one rising edge, then the
  // expected outputs just after that edge.
  task automatic addVec(input logic r, input logic [3:0] rq,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [3:0] g, input logic bz, input logic v,
                        input logic [1:0] id, input logic [1:0] d, input logic [7:0] cnt);
    vec_t t;
    t.rst = r; t.req = rq; t.a = a; t.b = b; t.c = c;
    t.grant = g; t.busy = bz; t.valid = v; t.id = id; t.data = d; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] g, input logic bz, input logic v,
                          input logic [1:0] id, input logic [1:0] d, input logic [7:0] cnt);
    checkOutput({tag, ".grant"},     32'(grant),     32'(g));
    checkOutput({tag, ".busy"},      32'(busy),      32'(bz));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, ".out_id"},    32'(out_id),    32'(id));
    checkOutput({tag, ".out_data"},  32'(out_data),  32'(d));
    checkOutput({tag, ".done_cnt"},  32'(done_cnt),  32'(cnt));
  endtask

  // Drive inputs 1 time unit after an edge, then sample 1 unit after the next.
  task automatic applyStimulus(input vec_t v);
    rst  = v.rst;
    req  = v.req;
    a_in = v.a;
    b_in = v.b;
    c_in = v.c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last_valid;
    int nvalid;

    checks = 0;
    fails  = 0;
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    c_in = '0;

    #1;
    checkAll("reset", 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    rst = 1'b0;

    // rst  req   a      b      c      grant busy v  id  data cnt
    // Single request: 3*3+1 = 10 -> 2
    addVec(0, 4'h1, 8'h03, 8'h03, 8'h01, 4'h1, 1, 0, 0, 0, 8'd0);
    addVec(0, 4'h0, 8'h03, 8'h03, 8'h01, 4'h0, 0, 1, 0, 2, 8'd1);
    addVec(0, 4'h0, 8'h03, 8'h03, 8'h01, 4'h0, 0, 0, 0, 2, 8'd1);
    // Reset back so requester 0 again has first priority
    addVec(1, 4'h0, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 0, 0, 0, 8'd0);
    // All four requesting, a_i=i, b=1, c=0: order 0,1,2,3,0
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h1, 1, 0, 0, 0, 8'd0);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 0, 0, 8'd1);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h2, 1, 0, 0, 0, 8'd1);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 1, 1, 8'd2);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h4, 1, 0, 1, 1, 8'd2);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 2, 2, 8'd3);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h8, 1, 0, 2, 2, 8'd3);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 3, 3, 8'd4);
    addVec(0, 4'hF, 8'hE4, 8'h55, 8'h00, 4'h1, 1, 0, 3, 3, 8'd4);
    addVec(0, 4'h0, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 0, 0, 8'd5);
    // Grant 1, then 1010 alternates 3,1,3
    addVec(0, 4'h2, 8'hE4, 8'h55, 8'h00, 4'h2, 1, 0, 0, 0, 8'd5);
    addVec(0, 4'hA, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 1, 1, 8'd6);
    addVec(0, 4'hA, 8'hE4, 8'h55, 8'h00, 4'h8, 1, 0, 1, 1, 8'd6);
    addVec(0, 4'hA, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 3, 3, 8'd7);
    addVec(0, 4'hA, 8'hE4, 8'h55, 8'h00, 4'h2, 1, 0, 3, 3, 8'd7);
    addVec(0, 4'hA, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 1, 1, 8'd8);
    addVec(0, 4'hA, 8'hE4, 8'h55, 8'h00, 4'h8, 1, 0, 1, 1, 8'd8);
    addVec(0, 4'h0, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 1, 3, 3, 8'd9);
    addVec(0, 4'h0, 8'hE4, 8'h55, 8'h00, 4'h0, 0, 0, 3, 3, 8'd9);
    // Requester 2: 2*2+3 = 7 -> 3, operands zeroed during EXEC
    addVec(0, 4'h4, 8'h20, 8'h20, 8'h30, 4'h4, 1, 0, 3, 3, 8'd9);
    addVec(0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 2, 3, 8'd10);
    addVec(0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 2, 3, 8'd10);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].valid,
               vecs[i].id, vecs[i].data, vecs[i].cnt);
    end

    // Reset asserted during EXEC aborts the operation immediately.
    req = 4'h1; a_in = 8'h03; b_in = 8'h03; c_in = 8'h01;
    @(posedge clk); #1;
    checkOutput("abort.grant_before", 32'(grant), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkAll("abort.async", 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    @(posedge clk); #1;
    checkOutput("abort.no_valid", 32'(out_valid), 32'h0);
    checkOutput("abort.cnt", 32'(done_cnt), 32'h0);
    rst = 1'b0; req = 4'h4; a_in = 8'h30; b_in = 8'h10; c_in = 8'h00;
    @(posedge clk); #1;
    checkOutput("abort.regrant", 32'(grant), 32'h4);
    req = 4'h0;
    @(posedge clk); #1;
    checkAll("abort.result", 4'h0, 1'b0, 1'b1, 2'd2, 2'd3, 8'd1);

    // Continuous single requester: 256 ops, counter wraps, result every 2 cycles.
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'h1; a_in = 8'h01; b_in = 8'h01; c_in = 8'h00;
    last_valid = -1;
    nvalid = 0;
    for (int cyc = 0; cyc < 512; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nvalid++;
        checkOutput("wrap.cnt", 32'(done_cnt), 32'(nvalid % 256));
        if (last_valid >= 0) checkOutput("wrap.gap", 32'(cyc - last_valid), 32'd2);
        last_valid = cyc;
      end
    end
    req = 4'h0;
    checkOutput("wrap.total", 32'(nvalid), 32'd256);
    checkOutput("wrap.final_cnt", 32'(done_cnt), 32'd0);
    checkOutput("wrap.final_data", 32'(out_data), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
